// File: rtl/mdu_stall_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers.
// The result is computed combinationally when the op is accepted and parked in
// pend_hi/pend_lo; it lands in HI/LO only when the modelled latency expires,
// so software sees the same busy window as an iterative unit would give.
// stall_req holds a D-stage MDU user while an op is in flight or being issued.
module mdu_stall_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        use_md_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_req
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          pend_wr_q, pend_wr_d;
    logic          busy_q, busy_d;

    logic          is_md_op, is_div, is_signed;
    logic [63:0]   prod;
    logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr;

    assign is_md_op  = (op >= OP_MULT) && (op <= OP_DIVU);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);

    assign hi        = hi_q;
    assign lo        = lo_q;
    assign busy      = busy_q;
    assign stall_req = use_md_d & (busy_q | (start & is_md_op));

    // Full-width result for the op presented this cycle; divide works on
    // magnitudes so MIN/-1 falls out as 0x80000000 rem 0 with no special case.
    always_comb begin
        if (op == OP_MULT) prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        else               prod = {32'b0, a} * {32'b0, b};
        a_mag  = (is_signed && a[31]) ? -a : a;
        b_mag  = (is_signed && b[31]) ? -b : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quo    = (is_signed && (a[31] ^ b[31])) ? -q_mag : q_mag;
        rem    = (is_signed && a[31]) ? -r_mag : r_mag;
        res_hi = is_div ? rem : prod[63:32];
        res_lo = is_div ? quo : prod[31:0];
        res_wr = !(is_div && (b == 32'd0));
    end

    // Next-state: accept ops in IDLE, count down in BUSY, retire on the last count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_md_op) begin
                        pend_hi_d = res_hi;
                        pend_lo_d = res_lo;
                        pend_wr_d = res_wr;
                        cnt_d     = is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        busy_d    = 1'b1;
                        state_d   = S_BUSY;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_BUSY: begin
                // Any start here is dropped; upstream stall_req keeps it from happening.
                if (cnt_q == CW'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset also discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: tb/tb_mdu_stall_unit.sv
// Bench for mdu_stall_unit: directed scenarios plus random traffic, all checked
// against a remaining-latency model that computes results with plain arithmetic.
module tb_mdu_stall_unit;
    localparam int MUL = 5;
    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        reset, start, use_md_d;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, stall_req;

    int passes = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    logic        m_pwr = 1'b0;
    int          m_rem = 0;

    mdu_stall_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .use_md_d(use_md_d), .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one clock edge with the given inputs.
    task automatic model_step(input logic rs, input logic st, input logic [2:0] o,
                              input logic [31:0] aa, input logic [31:0] bb);
        longint      sa, sb, p, q, r;
        logic [63:0] pu;
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        if (rs) begin
            m_hi = '0; m_lo = '0; m_rem = 0; m_pwr = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && m_pwr) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else if (st) begin
            case (o)
                3'd1: begin p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0]; m_pwr = 1'b1; m_rem = MUL; end
                3'd2: begin pu = {32'b0, aa} * {32'b0, bb}; m_phi = pu[63:32]; m_plo = pu[31:0]; m_pwr = 1'b1; m_rem = MUL; end
                3'd3: begin
                    m_pwr = (bb != 0);
                    if (bb != 0) begin q = sa / sb; r = sa % sb; m_plo = q[31:0]; m_phi = r[31:0]; end
                    m_rem = DIV;
                end
                3'd4: begin
                    m_pwr = (bb != 0);
                    if (bb != 0) begin m_plo = aa / bb; m_phi = aa % bb; end
                    m_rem = DIV;
                end
                3'd5: m_hi = aa;
                3'd6: m_lo = aa;
                default: ;
            endcase
        end
    endtask

    // One cycle: drive at negedge, check outputs against model, advance both.
    task automatic cyc(input logic rs, input logic st, input logic [2:0] o,
                       input logic [31:0] aa, input logic [31:0] bb, input logic u);
        logic exp_stall;
        @(negedge clk);
        reset = rs; start = st; op = o; a = aa; b = bb; use_md_d = u;
        #1;
        exp_stall = u && ((m_rem > 0) || (st && o >= 3'd1 && o <= 3'd4));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("stall_req", 32'(stall_req), 32'(exp_stall));
        @(posedge clk);
        model_step(rs, st, o, aa, bb);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; use_md_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_stall", 32'(stall_req), 32'd0);

        // MULT 3 * -2: five busy cycles, then result
        cyc(1'b0, 1'b1, 3'd1, 32'd3, 32'hFFFF_FFFE, 1'b0);
        chk("mult_busy0", 32'(busy), 32'd1);
        for (int i = 1; i < MUL; i++) begin
            idle(1);
            chk("mult_busy", 32'(busy), 32'd1);
        end
        idle(1);
        chk("mult_done", 32'(busy), 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2
        cyc(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MUL);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2, ten busy cycles
        cyc(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DIV - 1);
        chk("div_busy_last", 32'(busy), 32'd1);
        idle(1);
        chk("div_done", 32'(busy), 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0 leaves HI/LO alone but still takes the full latency
        cyc(1'b0, 1'b1, 3'd4, 32'd7, 32'd0, 1'b0);
        idle(DIV - 1);
        chk("divu0_busy", 32'(busy), 32'd1);
        idle(1);
        chk("divu0_hi", hi, 32'hFFFF_FFFF);
        chk("divu0_lo", lo, 32'hFFFF_FFFD);

        // Stall window with a D-stage user; MTHI during BUSY is dropped
        cyc(1'b0, 1'b1, 3'd1, 32'd6, 32'd7, 1'b1);
        cyc(1'b0, 1'b1, 3'd5, 32'd5, 32'd0, 1'b1);
        for (int i = 2; i < MUL; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        chk("stall_idle", 32'(stall_req), 32'd0);
        chk("mthi_ignored", hi, 32'd0);
        chk("mult67_lo", lo, 32'd42);
        cyc(1'b0, 1'b1, 3'd5, 32'd5, 32'd0, 1'b1);
        chk("mthi_hi", hi, 32'd5);
        chk("mthi_nobusy", 32'(busy), 32'd0);

        // Reset in busy cycle 4 of a DIV: nothing lands afterwards
        cyc(1'b0, 1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        idle(DIV + 2);
        chk("rst_no_late_lo", lo, 32'd0);

        // MIN / -1, then MULT issued the first idle cycle
        cyc(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
        cyc(1'b0, 1'b1, 3'd1, 32'd2, 32'd2, 1'b0);
        chk("b2b_busy", 32'(busy), 32'd1);
        idle(MUL);
        chk("b2b_lo", lo, 32'd4);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++)
            cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                pick_val(), pick_val(), 1'($urandom_range(0, 1)));
        idle(DIV + 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
